wb_load_store_unit: RTL and testbench

- Wishbone master sitting directly upstream of the combined instruction/data memory slave; the CPU datapath issues loads and stores here.
- Converts one RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) into a single Wishbone classic-pipelined transaction.
- Generates byte-lane selects, aligns store data, and extracts and extends load data.
- Signals completion, misalignment and bus timeout back to the CPU control FSM.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 64 ++++++
 rtl/wb_load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_wb_load_store_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the Wishbone load/store unit and its lane aligner.
//   - RV32I load/store funct3 codes
//   - FSM state encoding
//   - full byte-lane select constant and a funct3 legality helper
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] WB_SEL_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT_ACK,
    ST_DONE
  } state_t;

  // Stores only have signed-width encodings; loads add the unsigned forms.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane helper for a 32-bit Wishbone master.
//   funct3        : RV32I width/sign code
//   addr          : byte offset within the word (addr[1:0])
//   wdata         : right-justified store data
//   rdata         : raw word returned by the slave
//   sel           : byte-lane enables
//   aligned_wdata : store data replicated onto every lane of its width
//   ext_rdata     : selected byte/half, sign- or zero-extended
//   misaligned    : half not on a half boundary, or word not on a word boundary
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] aligned_wdata,
  output logic [31:0] ext_rdata,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = rdata[{addr, 3'b000} +: 8];
    rd_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    sel           = WB_SEL_ALL;
    aligned_wdata = wdata;
    misaligned    = 1'b0;
    case (funct3[1:0])
      2'd0: begin
        sel           = 4'b0001 << addr;
        aligned_wdata = {4{wdata[7:0]}};
      end
      2'd1: begin
        sel           = 4'b0011 << addr;
        aligned_wdata = {2{wdata[15:0]}};
        misaligned    = addr[0];
      end
      default: begin
        sel           = WB_SEL_ALL;
        aligned_wdata = wdata;
        misaligned    = (addr != 2'b00);
      end
    endcase
  end

  always_comb begin
    ext_rdata = rdata;
    case (funct3)
      F3_B:    ext_rdata = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   ext_rdata = {24'd0, rd_byte};
      F3_H:    ext_rdata = {{16{rd_half[15]}}, rd_half};
      F3_HU:   ext_rdata = {16'd0, rd_half};
      default: ext_rdata = rdata;
    endcase
  end

endmodule

// File: rtl/wb_load_store_unit.sv
// Wishbone classic-pipelined master for RV32I loads and stores.
//   i_req/i_we/i_funct3/i_addr/i_wdata : CPU request, sampled in IDLE only
//   o_busy/o_done/o_err/o_rdata        : CPU status; o_done is a one-cycle pulse
//   o_wb_* / i_wb_*                    : Wishbone master interface
// One request becomes one bus transaction; illegal or misaligned requests
// complete with o_err without touching the bus. All outputs are registered.
module wb_load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [31:0]           i_wb_data
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [1:0]    addr_lo_q;
  logic          first_stb;
  logic          err_q;
  logic [CW-1:0] count;
  logic [31:0]   word_q;

  logic [2:0]    lane_funct3;
  logic [1:0]    lane_addr;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;
  logic          lane_misaligned;
  logic          req_ok;

  // The aligner serves the incoming request in IDLE and the latched request
  // (for load extraction) everywhere else.
  always_comb begin
    lane_funct3 = (state == ST_IDLE) ? i_funct3     : funct3_q;
    lane_addr   = (state == ST_IDLE) ? i_addr[1:0]  : addr_lo_q;
    req_ok      = funct3_legal(i_we, i_funct3) && !lane_misaligned;
  end

  lsu_lane_align u_lane_align (
    .funct3        (lane_funct3),
    .addr          (lane_addr),
    .wdata         (i_wdata),
    .rdata         (word_q),
    .sel           (lane_sel),
    .aligned_wdata (lane_wdata),
    .ext_rdata     (lane_rdata),
    .misaligned    (lane_misaligned)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      first_stb <= 1'b0;
      err_q     <= 1'b0;
      count     <= '0;
      word_q    <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_sel  <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            o_busy    <= 1'b1;
            we_q      <= i_we;
            funct3_q  <= i_funct3;
            addr_lo_q <= i_addr[1:0];
            if (req_ok) begin
              err_q     <= 1'b0;
              first_stb <= 1'b1;
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= i_we;
              o_wb_addr <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
              o_wb_sel  <= lane_sel;
              o_wb_data <= lane_wdata;
              state     <= ST_STROBE;
            end else begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_STROBE: begin
          first_stb <= 1'b0;
          // An ack seen in the first strobe cycle is left over from the
          // previous transaction and must not complete this one.
          if (!first_stb && i_wb_ack) begin
            word_q   <= i_wb_data;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            state    <= ST_DONE;
          end else if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            count    <= '0;
            state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (i_wb_ack) begin
            word_q   <= i_wb_data;
            o_wb_cyc <= 1'b0;
            count    <= '0;
            state    <= ST_DONE;
          end else if (count == TIMEOUT_LAST) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            err_q    <= 1'b1;
            count    <= '0;
            state    <= ST_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_DONE: begin
          o_done <= 1'b1;
          o_err  <= err_q;
          o_busy <= 1'b0;
          if (!we_q && !err_q) o_rdata <= lane_rdata;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_load_store_unit.sv
// Self-checking bench for wb_load_store_unit: a table of request vectors is
// run through a procedural Wishbone slave, with expected completions held in
// a scoreboard queue and compared when o_done pulses.
module tb_wb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_data;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0, wb_stall = 1'b0;
  logic [31:0] wb_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_load_store_unit #(.ADDR_WIDTH(32), .ACK_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_err(err),
    .o_rdata(rdata), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          stall;
    logic        stale;
    int          delay;
    logic        noack;
    logic [3:0]  sel;
    logic [31:0] bus_data;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1 req = 1'b0;
    e.err       = v.err;
    e.chk_rdata = !v.we && !v.err;
    e.rdata     = v.rdata;
    e.acc       = cyc_cnt;
    if (v.err && !v.noack) e.lat = 1;
    else if (v.noack)      e.lat = 18 + v.stall;
    else                   e.lat = 3 + v.stall + v.delay;
    sb.push_back(e);
    if (v.err && !v.noack) begin
      repeat (2) begin
        @(negedge clk);
        check($sformatf("v%0d_no_cyc", idx), 32'(wb_cyc), 32'd0);
      end
    end else begin
      for (int c = 0; c <= v.stall; c++) begin
        @(negedge clk);
        check($sformatf("v%0d_stb", idx), 32'(wb_stb), 32'd1);
        check($sformatf("v%0d_addr", idx), wb_addr, v.addr & 32'hFFFF_FFFC);
        check($sformatf("v%0d_sel", idx), 32'(wb_sel), 32'(v.sel));
        check($sformatf("v%0d_we", idx), 32'(wb_we), 32'(v.we));
        if (v.we) check($sformatf("v%0d_wbdata", idx), wb_data, v.bus_data);
        if (c == 0) check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
        wb_stall = (c < v.stall);
        wb_ack   = (c == 0) && v.stale;
        wb_rdata = (c == 0 && v.stale) ? 32'hBAD0_BAD0 : 32'h0;
      end
      @(negedge clk);
      check($sformatf("v%0d_stb_drop", idx), 32'(wb_stb), 32'd0);
      wb_ack = 1'b0; wb_stall = 1'b0;
      if (!v.noack) begin
        repeat (v.delay) @(negedge clk);
        wb_ack = 1'b1; wb_rdata = v.word;
        @(negedge clk);
        wb_ack = 1'b0; wb_rdata = 32'h0;
      end
    end
    wait_drain();
  endtask

  initial begin
    //        we  f3    addr           wdata          word           st stale dly noack sel      bus_data       err  rdata
    vecs[0]  = '{1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0,         0, 1'b0, 0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'd1, 32'h0000_0202, 32'h0,         32'h8001_1234, 0, 1'b0, 0, 1'b0, 4'b1100, 32'h0,         1'b0, 32'hFFFF_8001};
    vecs[2]  = '{1'b0, 3'd5, 32'h0000_0202, 32'h0,         32'h8001_1234, 0, 1'b0, 0, 1'b0, 4'b1100, 32'h0,         1'b0, 32'h0000_8001};
    vecs[3]  = '{1'b0, 3'd2, 32'h0000_0101, 32'h0,         32'h0,         0, 1'b0, 0, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{1'b0, 3'd3, 32'h0000_0100, 32'h0,         32'h0,         0, 1'b0, 0, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{1'b1, 3'd4, 32'h0000_0100, 32'h0000_0011, 32'h0,         0, 1'b0, 0, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 3'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,         3, 1'b0, 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'd0, 32'h0000_0301, 32'h0,         32'h1234_F678, 0, 1'b1, 1, 1'b0, 4'b0010, 32'h0,         1'b0, 32'hFFFF_FFF6};
    vecs[8]  = '{1'b0, 3'd4, 32'h0000_0302, 32'h0,         32'h1234_F678, 0, 1'b0, 0, 1'b0, 4'b0100, 32'h0,         1'b0, 32'h0000_0034};
    vecs[9]  = '{1'b1, 3'd1, 32'h0000_0012, 32'h0000_BEEF, 32'h0,         0, 1'b0, 0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 3'd2, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 2, 1'b0, 4'b1111, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 3'd1, 32'h0000_0013, 32'h0000_1234, 32'h0,         0, 1'b0, 0, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[12] = '{1'b0, 3'd2, 32'h0000_0080, 32'h0,         32'h0,         1, 1'b0, 0, 1'b1, 4'b1111, 32'h0,         1'b1, 32'h0};

    // Completion monitor: every o_done must match the oldest expectation.
    fork
      forever begin
        @(negedge clk);
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_err", 32'(err), 32'(e.err));
            check("done_latency", 32'(cyc_cnt - e.acc), 32'(e.lat));
            check("done_cyc_low", 32'(wb_cyc), 32'd0);
            check("done_busy_low", 32'(busy), 32'd0);
            if (e.chk_rdata) check("done_rdata", rdata, e.rdata);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    rst_n = 1'b1;

    // Ack while idle must not start or finish anything.
    @(negedge clk);
    wb_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_ack_cyc", 32'(wb_cyc), 32'd0);
      check("idle_ack_busy", 32'(busy), 32'd0);
    end
    wb_ack = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reset during WAIT_ACK: outputs clear asynchronously, no completion.
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h0000_0044;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_cyc", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", 32'(wb_cyc), 32'd0);
    check("arst_stb", 32'(wb_stb), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdata", rdata, 32'd0);
    check("arst_addr", wb_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("post_rst_cyc", 32'(wb_cyc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
